fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised successor to the single-word fetch stage: a prefetching instruction fetch unit that issues sequential reads to a variable-latency instruction memory and buffers returned words, each tagged with its PC, in a DEPTH-entry queue. It sits between instruction memory and decode. Backpressure uses a valid/ready handshake instead of a global stall. Jump redirects flush the queue and discard in-flight responses without stalling memory.

## Interface
- ADDR_WIDTH, 12, byte-address width of PC and memory address
- WORD_WIDTH, 32, instruction width
- DEPTH, 4, queue entries and maximum outstanding reads; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- o_mem_req  out  1  read request valid
- o_mem_addr  out  ADDR_WIDTH  read address, low 2 bits always 0
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant
- i_mem_rdata  in  WORD_WIDTH  read data
- i_redirect  in  1  jump taken; flush and restart
- i_redirect_pc  in  ADDR_WIDTH  new fetch address; low 2 bits ignored and forced to 0
- o_valid  out  1  queue head valid
- o_inst  out  WORD_WIDTH  head instruction
- o_pc  out  ADDR_WIDTH  head instruction's PC
- i_ready  in  1  decode accepts the head

## Operation
- State: fetch_pc, inflight (granted, unreturned), drop (inflight responses to discard), queue count. All counters are clog2(DEPTH+1) bits wide.
- Request: o_mem_req = !i_rst && !i_redirect && (count + inflight − drop < DEPTH). Credit scheme: a returning response always has a free slot.
- Grant (o_mem_req && i_mem_gnt): inflight +1; fetch_pc += 4, modulo 2^ADDR_WIDTH (wraps to 0).
- Response: inflight −1. If drop > 0, drop −1 and the data is discarded. Otherwise push {fetch tag PC, rdata}. The tag PC comes from an internal issue-PC FIFO, or equivalently a pc-of-next-response register advanced by 4 per response.
- Pop: o_valid && i_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect cycle:
  - No request issued.
  - Queue cleared; any pop that cycle is ignored.
  - fetch_pc and response-tag PC ← i_redirect_pc & ~3.
  - drop ← inflight − i_mem_rvalid, plus 0; a response arriving in the redirect cycle is itself discarded.
- Back-to-back redirects: each recomputes drop from current inflight; the last one wins.
- Reset:
  - fetch_pc ← RESET_PC; count, inflight, drop ← 0.
  - o_valid = 0, o_mem_req = 0, o_inst = 0, o_pc = 0, o_mem_addr = RESET_PC.
  - Reset overrides redirect. Memory must be reset together with this block; responses to pre-reset requests are not tracked.

## Timing
- o_mem_addr = fetch_pc (registered); o_mem_req is combinational from state and i_redirect.
- Grant at cycle N → earliest rvalid N+1 → earliest o_valid N+2 (queue write registered, no bypass).
- Redirect at cycle R → first request with the new PC at R+1 → earliest o_valid R+3.
- o_valid/o_inst/o_pc are held stable while o_valid && !i_ready and no redirect occurs.
- Sustained throughput of 1 instruction/cycle with single-cycle memory, i_gnt = 1 and i_ready = 1.

## Structure
- Package fetch_pkg:
  - INST_BYTES = 4
  - typedef fetch_entry_t {pc, inst}, parametrised through localparams of the including module
- Sub-module fetch_fifo:
  - synchronous FIFO of fetch_entry_t, DEPTH entries
  - ports: push, pop, clear, full, empty, count
  - pointers wrap at DEPTH

## Test plan
- Reset, single-cycle memory, gnt=1, ready=1 → requests to 0,4,8,12… on consecutive cycles; first o_valid 2 cycles after the first grant; o_pc sequence 0,4,8 with matching rdata.
- i_ready=0 held → exactly DEPTH (4) grants, then o_mem_req=0; head stays PC 0; after ready=1, all four drain in order and requesting resumes.
- Memory latency 3, redirect to 0x008 while 2 reads are in flight → drop=2; both stale responses discarded; next o_pc = 0x008; no stale entry ever reaches o_valid.
- Redirect in the same cycle as rvalid and ready pop → response discarded, pop ignored, o_valid=0 next cycle, new request at R+1.
- fetch_pc 0xFFC with ADDR_WIDTH=12 → next request address 0x000, o_pc wraps accordingly.
- i_rst asserted mid-stream with queue full and i_redirect=1 → next cycle count=0, o_valid=0, o_mem_addr=RESET_PC, redirect ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the prefetching fetch unit
package fetch_pkg;

   localparam int INST_BYTES = 4;

   // Counters must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of {pc, inst} fetch entries
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 4,
   localparam int CW        = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_pc,
   input  logic [WORD_WIDTH-1:0] push_inst,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] head_pc,
   output logic [WORD_WIDTH-1:0] head_inst,
   output logic                  full,
   output logic                  empty,
   output logic [CW-1:0]         count
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] inst;
   } fetch_entry_t;

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
   end

   // Empty slots read as zero so the head is clean out of reset.
   assign head_pc   = empty ? '0 : mem[rd_ptr].pc;
   assign head_inst = empty ? '0 : mem[rd_ptr].inst;

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - prefetching instruction fetch unit with redirect flush
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    WORD_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_gnt,
   input  logic                  i_mem_rvalid,
   input  logic [WORD_WIDTH-1:0] i_mem_rdata,
   input  logic                  i_redirect,
   input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
   output logic                  o_valid,
   output logic [WORD_WIDTH-1:0] o_inst,
   output logic [ADDR_WIDTH-1:0] o_pc,
   input  logic                  i_ready
);

   localparam int                    CW         = cnt_width(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INST_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INST_BYTES - 1);

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] tag_pc;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         drop;
   logic [CW-1:0]         count;
   logic [CW:0]           committed;
   logic                  grant;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;

   // Every live outstanding read owns a queue slot, so returning data always fits.
   assign committed  = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};
   assign o_mem_req  = !i_rst && !i_redirect && (committed < (CW+1)'(DEPTH));
   assign o_mem_addr = fetch_pc;
   assign grant      = o_mem_req && i_mem_gnt;
   assign push       = i_mem_rvalid && (drop == '0) && !i_redirect && !full;
   assign pop        = o_valid && i_ready && !i_redirect;
   assign o_valid    = !empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_pc <= RESET_PC & ALIGN_MASK;
         tag_pc   <= RESET_PC & ALIGN_MASK;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight + CW'(grant) - CW'(i_mem_rvalid);
         if (i_redirect) begin
            fetch_pc <= i_redirect_pc & ALIGN_MASK;
            tag_pc   <= i_redirect_pc & ALIGN_MASK;
            drop     <= inflight - CW'(i_mem_rvalid);
         end else begin
            if (grant) fetch_pc <= fetch_pc + PC_STEP;
            if (i_mem_rvalid) begin
               if (drop != '0) drop   <= drop - CW'(1);
               else            tag_pc <= tag_pc + PC_STEP;
            end
         end
      end
   end

   fetch_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .clear     (i_redirect),
      .push      (push),
      .push_pc   (tag_pc),
      .push_inst (i_mem_rdata),
      .pop       (pop),
      .head_pc   (o_pc),
      .head_inst (o_inst),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - scoreboard bench for fetch_prefetch
module tb_fetch_prefetch;

   logic        clk = 1'b0;
   logic        rst, mem_req, mem_gnt, mem_rvalid, redirect, valid, ready;
   logic [11:0] mem_addr, redirect_pc, pc;
   logic [31:0] mem_rdata, inst;

   always #5 clk = ~clk;

   fetch_prefetch #(
      .ADDR_WIDTH (12),
      .WORD_WIDTH (32),
      .DEPTH      (4),
      .RESET_PC   (12'h000)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .o_mem_req     (mem_req),
      .o_mem_addr    (mem_addr),
      .i_mem_gnt     (mem_gnt),
      .i_mem_rvalid  (mem_rvalid),
      .i_mem_rdata   (mem_rdata),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_valid       (valid),
      .o_inst        (inst),
      .o_pc          (pc),
      .i_ready       (ready)
   );

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      int          due;
      int          epoch;
   } mreq_t;

   typedef struct {
      logic [11:0] pc;
      logic [31:0] inst;
   } exp_t;

   mreq_t       mq[$];
   exp_t        sb[$];
   int          vectors = 0, miscompares = 0;
   int          cyc = 0, lat = 1, epoch = 0, grants = 0, pops = 0;
   int          first_grant_cyc = -1, first_valid_cyc = -1;
   logic [11:0] exp_addr = '0, first_pop_pc = '0, prev_pop_pc = '0;
   bit          saw_pop = 0, saw_wrap = 0;

   function automatic logic [31:0] word_at(input logic [11:0] a);
      return {4'hA, a, 4'h5, ~a};
   endfunction

   task automatic reset_model();
      mq.delete();
      sb.delete();
      exp_addr        = 12'h000;
      epoch           = 0;
      grants          = 0;
      pops            = 0;
      first_grant_cyc = -1;
      first_valid_cyc = -1;
      saw_pop         = 0;
      saw_wrap        = 0;
   endtask

   task automatic do_reset();
      rst = 1; redirect = 0; redirect_pc = '0; ready = 1; mem_gnt = 1;
      mem_rvalid = 0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      reset_model();
   endtask

   // One clock: present memory response, score outputs, advance models, step the edge.
   task automatic cycle();
      mreq_t r;
      exp_t  e;
      mem_rvalid = 0;
      mem_rdata  = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mem_rvalid = 1;
         mem_rdata  = mq[0].data;
      end
      #1;
      vectors++;
      if (valid !== (sb.size() != 0)) begin
         miscompares++;
         $display("FAIL occupancy: o_valid=%b expected %b at cycle %0d", valid, sb.size() != 0, cyc);
      end
      if (valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (redirect) begin
         vectors++;
         if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL req_during_redirect: o_mem_req=%b expected 0", mem_req);
         end
      end
      if (valid && ready && !redirect && sb.size() != 0) begin
         e = sb.pop_front();
         vectors++;
         if (pc !== e.pc || inst !== e.inst) begin
            miscompares++;
            $display("FAIL head: pc=%h inst=%h expected pc=%h inst=%h", pc, inst, e.pc, e.inst);
         end
         if (!saw_pop) first_pop_pc = pc;
         if (saw_pop && prev_pop_pc == 12'hFFC && pc == 12'h000) saw_wrap = 1;
         saw_pop     = 1;
         prev_pop_pc = pc;
         pops++;
      end
      if (mem_req && mem_gnt) begin
         vectors++;
         if (mem_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL req_addr: o_mem_addr=%h expected %h", mem_addr, exp_addr);
         end
         mq.push_back('{mem_addr, word_at(mem_addr), cyc + lat, epoch});
         exp_addr = exp_addr + 12'd4;
         grants++;
         if (first_grant_cyc < 0) first_grant_cyc = cyc;
      end
      if (mem_rvalid) begin
         r = mq.pop_front();
         if (r.epoch == epoch && !redirect) sb.push_back('{r.addr, r.data});
      end
      if (redirect) begin
         sb.delete();
         epoch++;
         exp_addr = redirect_pc & 12'hFFC;
         saw_pop  = 0;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst = 1; redirect = 1; redirect_pc = 12'h040; ready = 1; mem_gnt = 1;
      mem_rvalid = 0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors += 5;
      if (valid !== 1'b0)         begin miscompares++; $display("FAIL reset_valid: %b expected 0", valid); end
      if (mem_req !== 1'b0)       begin miscompares++; $display("FAIL reset_req: %b expected 0", mem_req); end
      if (inst !== 32'h0)         begin miscompares++; $display("FAIL reset_inst: %h expected 0", inst); end
      if (pc !== 12'h000)         begin miscompares++; $display("FAIL reset_pc: %h expected 0", pc); end
      if (mem_addr !== 12'h000)   begin miscompares++; $display("FAIL reset_addr: %h expected 0", mem_addr); end
      redirect = 0;
   endtask

   task automatic test_stream();
      int c;
      do_reset();
      lat = 1;
      c   = cyc;
      repeat (20) cycle();
      vectors += 4;
      if (first_grant_cyc != c) begin miscompares++; $display("FAIL stream_first_grant: cycle %0d expected %0d", first_grant_cyc, c); end
      if (first_valid_cyc - first_grant_cyc != 2) begin
         miscompares++; $display("FAIL stream_latency: %0d expected 2", first_valid_cyc - first_grant_cyc);
      end
      if (grants != 20) begin miscompares++; $display("FAIL stream_grants: %0d expected 20", grants); end
      if (pops != 18)   begin miscompares++; $display("FAIL stream_pops: %0d expected 18", pops); end
   endtask

   task automatic test_backpressure();
      do_reset();
      lat   = 1;
      ready = 0;
      repeat (10) cycle();
      vectors += 4;
      if (grants != 4)      begin miscompares++; $display("FAIL bp_grants: %0d expected 4", grants); end
      if (mem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req: %b expected 0", mem_req); end
      if (valid !== 1'b1)   begin miscompares++; $display("FAIL bp_valid: %b expected 1", valid); end
      if (pc !== 12'h000)   begin miscompares++; $display("FAIL bp_head_pc: %h expected 000", pc); end
      ready = 1;
      repeat (10) cycle();
      vectors += 2;
      if (pops != 10)   begin miscompares++; $display("FAIL bp_drain_pops: %0d expected 10", pops); end
      if (grants != 13) begin miscompares++; $display("FAIL bp_resume_grants: %0d expected 13", grants); end
   endtask

   task automatic test_redirect_inflight();
      do_reset();
      lat     = 3;
      mem_gnt = 1;
      cycle();
      cycle();
      mem_gnt     = 0;
      redirect    = 1;
      redirect_pc = 12'h00A;
      cycle();
      redirect = 0;
      mem_gnt  = 1;
      #1;
      vectors += 2;
      if (mem_req !== 1'b1)     begin miscompares++; $display("FAIL rd_req_after: %b expected 1", mem_req); end
      if (mem_addr !== 12'h008) begin miscompares++; $display("FAIL rd_addr_after: %h expected 008", mem_addr); end
      repeat (12) cycle();
      vectors++;
      if (!saw_pop || first_pop_pc !== 12'h008) begin
         miscompares++; $display("FAIL rd_first_pc: %h (seen %0d) expected 008", first_pop_pc, saw_pop);
      end
   endtask

   task automatic test_redirect_same_cycle();
      int r_cyc;
      do_reset();
      lat   = 1;
      ready = 1;
      repeat (5) cycle();
      vectors += 2;
      if (valid !== 1'b1) begin miscompares++; $display("FAIL sc_pre_valid: %b expected 1", valid); end
      if (!(mq.size() > 0 && mq[0].due <= cyc)) begin
         miscompares++; $display("FAIL sc_pre_rvalid: response not pending, expected one");
      end
      r_cyc       = cyc;
      redirect    = 1;
      redirect_pc = 12'h100;
      cycle();
      redirect = 0;
      #1;
      vectors += 3;
      if (valid !== 1'b0)       begin miscompares++; $display("FAIL sc_valid_after: %b expected 0", valid); end
      if (mem_req !== 1'b1)     begin miscompares++; $display("FAIL sc_req_after: %b expected 1", mem_req); end
      if (mem_addr !== 12'h100) begin miscompares++; $display("FAIL sc_addr_after: %h expected 100", mem_addr); end
      first_valid_cyc = -1;
      repeat (6) cycle();
      vectors += 2;
      if (first_valid_cyc != r_cyc + 3) begin
         miscompares++; $display("FAIL sc_latency: cycle %0d expected %0d", first_valid_cyc, r_cyc + 3);
      end
      if (first_pop_pc !== 12'h100) begin miscompares++; $display("FAIL sc_first_pc: %h expected 100", first_pop_pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      lat         = 1;
      redirect    = 1;
      redirect_pc = 12'hFF8;
      cycle();
      redirect = 0;
      repeat (8) cycle();
      vectors++;
      if (!saw_wrap) begin miscompares++; $display("FAIL wrap: no FFC->000 pop seen, expected one"); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      lat   = 1;
      ready = 0;
      repeat (8) cycle();
      vectors++;
      if (valid !== 1'b1) begin miscompares++; $display("FAIL rm_full_valid: %b expected 1", valid); end
      rst         = 1;
      redirect    = 1;
      redirect_pc = 12'h200;
      mem_rvalid  = 0;
      @(posedge clk);
      cyc++;
      #1;
      vectors += 3;
      if (valid !== 1'b0)       begin miscompares++; $display("FAIL rm_valid: %b expected 0", valid); end
      if (mem_req !== 1'b0)     begin miscompares++; $display("FAIL rm_req: %b expected 0", mem_req); end
      if (mem_addr !== 12'h000) begin miscompares++; $display("FAIL rm_addr: %h expected 000", mem_addr); end
      rst      = 0;
      redirect = 0;
      ready    = 1;
      reset_model();
      #1;
      vectors += 2;
      if (mem_req !== 1'b1)     begin miscompares++; $display("FAIL rm_req_after: %b expected 1", mem_req); end
      if (mem_addr !== 12'h000) begin miscompares++; $display("FAIL rm_addr_after: %h expected 000", mem_addr); end
      repeat (6) cycle();
      vectors++;
      if (!saw_pop || first_pop_pc !== 12'h000) begin
         miscompares++; $display("FAIL rm_first_pc: %h expected 000", first_pop_pc);
      end
   endtask

   initial begin
      rst = 1; redirect = 0; redirect_pc = '0; ready = 1; mem_gnt = 1;
      mem_rvalid = 0; mem_rdata = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_same_cycle();
      test_wrap();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
